seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Parametrised N-digit multiplexed 7-segment display controller.
//  - Runs from the system clock through an internal scan prescaler, so no divided display clock is needed.
//  - Double-buffers display data and commits updates only at frame boundaries, so there is no tearing.
//  - Adds leading-zero blanking, per-digit blink and an anode dead-time cycle against ghosting.
//  - Sits at the top level, driving the board AN/HEX pins from debug or MMIO data.
// PARAMETERS
//  DIGITS     8           number of digits; SEL_W = $clog2(DIGITS)
//  CLK_HZ     50_000_000  o_clk frequency
//  SCAN_HZ    10_000      digit-step rate; TICK_MAX = CLK_HZ/SCAN_HZ-1, must be >= 1
//  BLINK_DIV  5_000       scan ticks per blink half-period, must be >= 1
// PORTS
//  o_clk       in   1         system clock, posedge
//  rst         in   1         reset, asynchronous, active-low
//  value       in   4*DIGITS  nibble i = digit i; digit 0 is rightmost/LSB
//  dots        in   DIGITS    decimal point per digit, 1 = lit
//  en          in   DIGITS    digit enable, 0 = always dark
//  blink       in   DIGITS    1 = digit blanked during blink phase 1
//  lzb         in   1         leading-zero blanking enable
//  upd         in   1         1-cycle strobe: capture value/dots/en/blink/lzb into staging
//  upd_ack     out  1         1-cycle pulse when staging is committed to active
//  frame_start out  1         1-cycle pulse when select wraps to digit 0
//  an          out  DIGITS    active-low anode select, registered
//  hex         out  8         active-low {dp,g,f,e,d,c,b,a}, registered
// BEHAVIOUR
//  Reset (async, on rst=0):
//  - prescaler=0, select=0, blink_cnt=0, phase=0, pending=0.
//  - staging/active regs=0 (en=0); an='1, hex=8'hFF; upd_ack=0, frame_start=0.
//  Scan timing:
//  - Prescaler counts 0..TICK_MAX. tick = (prescaler==TICK_MAX), prescaler then wraps to 0.
//  - On tick, select <= (select==DIGITS-1) ? 0 : select+1. Non-power-of-2 DIGITS wraps at DIGITS-1.
//  Dead time: in the cycle where tick=1, an <= '1 and hex <= 8'hFF. On every non-tick cycle, an/hex drive the digit at select.
//  - The new digit therefore appears 2 cycles after the tick edge.
//  - an = ~(1<<select) when the digit is visible; otherwise '1.
//  Frame boundary: tick && select==DIGITS-1.
//  - frame_start pulses in the cycle after the boundary.
//  Update handshake:
//  - upd=1: staging <= inputs, pending <= 1.
//  - Boundary && pending: active <= staging, pending <= 0, upd_ack pulses on the next cycle.
//  - upd in the same cycle as a boundary: inputs bypass staging straight into active; pending stays 0; upd_ack pulses.
//  - Multiple upd strobes before a boundary: last capture wins, with a single ack.
//  Visibility of digit i: active.en[i] && !(active.blink[i] && phase) && !lz[i].
//  - lz[i]=1 iff lzb && i!=0 && value nibbles i..DIGITS-1 are all zero. Digit 0 is never zero-blanked.
//  - The dot of an lz-blanked digit is also dark.
//  Blink: blink_cnt increments on tick. When it reaches BLINK_DIV-1 it wraps to 0 and phase toggles.
//  Glyph table (active-low, dp bit = ~dot):
//  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E, each with bit7 = ~dot.
//  Reset mid-frame: outputs go dark immediately; pending is lost; no upd_ack is produced.
//  All counter widths come from $clog2 of their limits; no truncation warnings are allowed.
// STRUCTURE
//  Package seg_pkg:
//  - seg_t (logic [7:0]), SEG_BLANK = 8'hFF, GLYPH[16] constant table.
//  - disp_cfg_t struct {value, dots, en, blink, lzb}, parametrised via DIGITS in the module.
//  Sub-module seg7_decode: nibble + dot -> seg_t, purely combinational lookup in GLYPH.
//  Top level holds prescaler, select, blink counter, staging/active regs, lz priority chain and output regs.
// TESTING (sim: CLK_HZ=100, SCAN_HZ=10 -> TICK_MAX=9; DIGITS=8; BLINK_DIV=2)
//  1. Reset release, en=0 -> an=FF and hex=FF throughout; first tick at cycle 10, select=1 afterwards.
//  2. value=32'h0000_1234, en=FF, lzb=0, upd at cycle 3 -> upd_ack at boundary+1; at select=0: an=FE, hex=99.
//  3. Same value with lzb=1 -> digits 7..4 have an bit high; digit 3 shows F9 (an=F7).
//  4. value=0, lzb=1, dots[0]=1 -> only digit 0 lit, hex=40; digits 1..7 dark.
//  5. upd mid-frame with new value -> old value persists until select wraps; upd_ack exactly 1 cycle; upd coincident with boundary -> immediate commit.
//  6. blink=8'h04 -> digit 2 alternates visible/dark every 2 ticks; rst low mid-scan -> an=FF at once, no ack after release.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: segment types and active-low glyph table shared by the scan controller
package seg_pkg;
  typedef logic [7:0] seg_t;
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble plus decimal point to active-low {dp,g..a} segment pattern
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dot,
  output logic [7:0] seg
);
  assign seg = {~dot, GLYPH[nib][6:0]};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed N-digit 7-segment scanner with frame-synchronous double buffering
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 10_000,
  parameter int BLINK_DIV = 5_000
) (
  input  logic                  o_clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzb,
  input  logic                  upd,
  output logic                  upd_ack,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            hex
);
  localparam int TICK_MAX = CLK_HZ / SCAN_HZ - 1;
  localparam int PS_W     = TICK_MAX > 0 ? $clog2(TICK_MAX + 1) : 1;
  localparam int SEL_W    = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int BL_W     = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_MAX);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dots;
    logic [DIGITS-1:0]   en;
    logic [DIGITS-1:0]   blink;
    logic                lzb;
  } disp_cfg_t;

  disp_cfg_t         cfg_in, staging, active;
  logic [PS_W-1:0]   ps;
  logic [SEL_W-1:0]  sel;
  logic [BL_W-1:0]   bcnt;
  logic              phase, pending, tick, boundary, zero_run;
  logic [DIGITS-1:0] lz, vis;
  logic [3:0]        nib;
  logic [7:0]        glyph;

  assign cfg_in   = '{value: value, dots: dots, en: en, blink: blink, lzb: lzb};
  assign tick     = ps == PS_LAST;
  assign boundary = tick && sel == SEL_LAST;
  assign vis      = active.en & ~(active.blink & {DIGITS{phase}}) & ~lz;
  assign nib      = active.value[4*sel +: 4];

  seg7_decode u_dec (.nib(nib), .dot(active.dots[sel]), .seg(glyph));

  // leading-zero chain: a digit blanks while every nibble from it upward is zero
  always_comb begin
    zero_run = active.lzb;
    lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && active.value[4*i +: 4] == 4'h0;
      lz[i] = i != 0 && zero_run;
    end
  end

  // scan prescaler, digit select and blink phase
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      ps <= '0;
      sel <= '0;
      bcnt <= '0;
      phase <= 1'b0;
    end else begin
      ps <= tick ? '0 : ps + 1'b1;
      if (tick) begin
        sel <= sel == SEL_LAST ? '0 : sel + 1'b1;
        bcnt <= bcnt == BL_LAST ? '0 : bcnt + 1'b1;
        phase <= bcnt == BL_LAST ? ~phase : phase;
      end
    end
  end

  // staging capture and frame-boundary commit, with bypass when upd hits the boundary
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      staging <= '0;
      active <= '0;
      pending <= 1'b0;
      upd_ack <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (upd) staging <= cfg_in;
      if (boundary && upd) active <= cfg_in;
      else if (boundary && pending) active <= staging;
      pending <= boundary ? 1'b0 : pending | upd;
      upd_ack <= boundary && (upd || pending);
      frame_start <= boundary;
    end
  end

  // registered pins, dark for one dead-time cycle on every digit step
  always_ff @(posedge o_clk or negedge rst) begin
    if (!rst) begin
      an <= '1;
      hex <= SEG_BLANK;
    end else begin
      an <= !tick && vis[sel] ? ~(DIGITS'(1) << sel) : '1;
      hex <= !tick && vis[sel] ? glyph : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scoreboard bench for the 8-digit scanner at TICK_MAX=9, BLINK_DIV=2
module tb_seg_scan_ctrl;
  logic        o_clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = '0;
  logic [7:0]  dots = '0, en = '0, blink = '0;
  logic        lzb = 1'b0, upd = 1'b0;
  logic        upd_ack, frame_start;
  logic [7:0]  an, hex;

  typedef struct { logic [7:0] an; logic [7:0] hex; } exp_t;
  exp_t exp_q [$];
  int compared = 0;
  int mismatched = 0;

  seg_scan_ctrl #(.DIGITS(8), .CLK_HZ(100), .SCAN_HZ(10), .BLINK_DIV(2)) dut (
    .o_clk(o_clk), .rst(rst), .value(value), .dots(dots), .en(en), .blink(blink),
    .lzb(lzb), .upd(upd), .upd_ack(upd_ack), .frame_start(frame_start), .an(an), .hex(hex)
  );

  always #5 o_clk = ~o_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] h);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.hex = h[8*k +: 8];
      e.an = e.hex == 8'hFF ? 8'hFF : ~(8'h01 << k);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_frame(input string tag, input int first_wait);
    exp_t e;
    repeat (first_wait) @(negedge o_clk);
    for (int k = 0; k < 8; k++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.an = 8'h00; e.hex = 8'h00; end
      chk($sformatf("%s_digit%0d", tag, k), {an, hex}, {e.an, e.hex});
      if (k < 7) repeat (10) @(negedge o_clk);
    end
  endtask

  task automatic wait_frame(output int n, output int lit);
    n = 0;
    lit = 0;
    do begin
      @(negedge o_clk);
      n++;
      if (an !== 8'hFF || hex !== 8'hFF) lit++;
    end while (frame_start !== 1'b1 && n < 200);
    chk("frame_start_seen", frame_start, 1);
  endtask

  task automatic drive_upd(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e,
                           input logic [7:0] b, input logic l);
    value = v; dots = d; en = e; blink = b; lzb = l; upd = 1'b1;
    @(negedge o_clk);
    upd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lit;
    #1 rst = 1'b0;
    #1;
    chk("reset_an", an, 8'hFF);
    chk("reset_hex", hex, 8'hFF);
    chk("reset_ack", upd_ack, 0);
    chk("reset_frame_start", frame_start, 0);
    @(negedge o_clk);
    @(negedge o_clk);
    #2 rst = 1'b1;
    // staged data must stay invisible for the whole first frame
    repeat (3) @(negedge o_clk);
    drive_upd(32'h0000_1234, 8'h00, 8'hFF, 8'h00, 1'b0);
    wait_frame(n, lit);
    chk("first_frame_cycles", n + 4, 80);
    chk("first_frame_dark", lit, 0);
    chk("ack_plain", upd_ack, 1);
    @(negedge o_clk);
    chk("ack_one_cycle", upd_ack, 0);
    push_frame(64'hC0C0C0C0_F9A4B099);
    check_frame("plain", 4);
    // mid-frame update with lzb: old frame above already held until the wrap
    drive_upd(32'h0000_1234, 8'h00, 8'hFF, 8'h00, 1'b1);
    wait_frame(n, lit);
    chk("ack_lzb", upd_ack, 1);
    @(negedge o_clk);
    chk("ack_lzb_one_cycle", upd_ack, 0);
    push_frame(64'hFFFFFFFF_F9A4B099);
    check_frame("lzb", 4);
    // two strobes in one frame: the later capture is shown
    drive_upd(32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    @(negedge o_clk);
    drive_upd(32'h0000_0000, 8'h01, 8'hFF, 8'h00, 1'b1);
    wait_frame(n, lit);
    chk("ack_zero", upd_ack, 1);
    @(negedge o_clk);
    chk("ack_zero_one_cycle", upd_ack, 0);
    push_frame(64'hFFFFFFFF_FFFFFF40);
    check_frame("all_zero", 4);
    // strobe in the boundary cycle commits immediately
    repeat (4) @(negedge o_clk);
    drive_upd(32'hFEDC_BA98, 8'h80, 8'hEF, 8'h00, 1'b1);
    chk("bypass_frame_start", frame_start, 1);
    chk("bypass_ack", upd_ack, 1);
    @(negedge o_clk);
    chk("bypass_ack_one_cycle", upd_ack, 0);
    push_frame(64'h0E86A1FF_83889080);
    check_frame("bypass", 4);
    wait_frame(n, lit);
    chk("no_ack_after_bypass", upd_ack, 0);
    // blink phase is 0 for digits 0,1,4,5 and 1 for digits 2,3,6,7 in every frame
    drive_upd(32'h7654_3210, 8'h00, 8'hFF, 8'h15, 1'b0);
    wait_frame(n, lit);
    chk("ack_blink", upd_ack, 1);
    @(negedge o_clk);
    chk("ack_blink_one_cycle", upd_ack, 0);
    push_frame(64'hF8829299_B0FFF9C0);
    check_frame("blink", 4);
    // reset while digit 7 is lit and an update is pending
    drive_upd(32'h1111_1111, 8'h00, 8'hFF, 8'h00, 1'b0);
    @(negedge o_clk);
    #2 rst = 1'b0;
    #1;
    chk("midscan_reset_an", an, 8'hFF);
    chk("midscan_reset_hex", hex, 8'hFF);
    chk("midscan_reset_ack", upd_ack, 0);
    repeat (2) @(negedge o_clk);
    #2 rst = 1'b1;
    wait_frame(n, lit);
    chk("post_reset_cycles", n, 80);
    chk("post_reset_dark", lit, 0);
    chk("post_reset_no_ack", upd_ack, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
